i2c_master: RTL and testbench
=============================

# i2c_master

Single-master I2C bus controller that generates transactions toward the game-board I2C slave at address 0x55. Game-side logic issues one command: address, direction, 0–4 bytes. This block then produces the complete START / address / data / ACK / STOP sequence on SCL/SDA. For writes it sends the command byte followed by up to three data bytes. For reads it collects the 4-byte rank-memory readout. It sits directly upstream of the slave on the shared bus.

## Interface
- CLK_DIV, 250: system clocks per SCL quarter-period; legal minimum 4, so the slave's 2-FF synchronisers see every edge.
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only when busy=0
- rw  in  1  0 = write, 1 = read
- slv_addr  in  7  target 7-bit address
- num_bytes  in  3  data bytes to transfer; 0 = address-only probe; values >4 clamp to 4
- tx_data  in  32  write bytes; byte0 = [31:24], byte3 = [7:0]
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when the transaction ends
- ack_err  out  1  slave NACKed address or a write byte; sticky until next accepted start
- rx_data  out  32  read bytes, same byte order as tx_data
- SCL  out  1  bus clock, push-pull, idle 1
- SDA  inout  1  open-drain: driven 0 or released (z); never driven 1

## Operation
- Accept: start=1 and busy=0.
  - Latch rw, slv_addr, num_bytes (clamped), tx_data.
  - Clear ack_err.
  - Clear rx_data to 0 when rw=1.
  - Set busy.
- start while busy=1 is ignored, with no side effects.
- Quarter-phase engine: a counter counts CLK_DIV clocks per quarter; each bit slot is 4 quarters, q0..q3.
  - q0/q1: SCL=0. The new SDA value is applied at entry to q0.
  - q2/q3: SCL=1. SDA is sampled on the last clock of q2.
- States: IDLE → START → ADDR → ADDR_ACK → {WDATA ↔ WACK | RDATA ↔ RACK} → STOP → IDLE.
- START: q0/q1 SCL=1, SDA released; q2/q3 SCL=1, SDA=0. ADDR q0 then drops SCL while SDA=0, which is the slave's start detect.
- ADDR: 8 bits {slv_addr, rw}, MSB first.
- ADDR_ACK: SDA released.
  - Sampled 1 → ack_err=1, go to STOP.
  - num_bytes=0 → go to STOP.
  - Otherwise → WDATA or RDATA.
- WDATA/WACK:
  - Shift out tx_data bytes in order, then release SDA for the ACK slot.
  - NACK → ack_err=1, go to STOP.
  - The last byte ACKed → go to STOP.
- RDATA/RACK:
  - SDA released while shifting in 8 bits MSB first into byte k of rx_data.
  - RACK drives SDA=0 (ACK) for bytes 0..n-2 and releases SDA (NACK) on byte n-1, then goes to STOP.
- STOP:
  - q0: SCL=0, SDA=0.
  - q1: SCL=1, SDA=0.
  - q2/q3: SCL=1, SDA released (rising SDA with SCL high).
- On the last clock of STOP:
  - done=1 for one cycle and busy=0 in the same cycle.
  - rx_data and ack_err are final and valid there.
- A byte counter of 2 bits plus a done flag tracks n; no byte beyond num_bytes is ever put on the bus.

## Timing
- Reset values:
  - SCL=1, SDA released, busy=0, done=0, ack_err=0, rx_data=0, state IDLE.
  - The quarter counter is cleared.
- Reset mid-transaction: lines return to idle immediately (asynchronously). No STOP is generated and no done pulse is emitted.
- busy rises in the cycle after the accepting edge.
- Normal completion: done is high exactly 1 + 4·CLK_DIV·(11 + 9·n) clocks after the accepting edge, where n = clamped num_bytes.
- Early abort on NACK: the transfer skips remaining bytes and goes straight to STOP.
  - Address NACK: done after 1 + 4·CLK_DIV·11.
  - NACK on write byte k (0-based): done after 1 + 4·CLK_DIV·(11 + 9·(k+1)).
- A new start may be accepted in the cycle after done.
- SDA changes only while SCL=0, except in START and STOP.

## Test plan
- Write, CLK_DIV=4, addr 0x55, n=4, tx 0x11_12_34_41.
  - Bus monitor decodes START, 0xAA, 0x11, 0x12, 0x34, 0x41, STOP.
  - Every slot is ACKed; ack_err=0; done at cycle 1+16·47=753.
- Read, addr 0x55, n=4, slave model returns DE, AD, BE, EF.
  - rx_data=0xDEADBEEF.
  - Master ACKs bytes 0–2 and NACKs byte 3; address byte seen as 0xAB.
- Address NACK: addr 0x22 with no responder.
  - ack_err=1; STOP immediately after the address ACK slot; done at cycle 177; no data bits driven.
- Write NACK: n=3, slave NACKs byte 1.
  - ack_err=1; byte 2 never appears; done at 1+16·29=465.
- Edge cases:
  - num_bytes=0 → START, 0xAA, ACK, STOP, done at 177.
  - num_bytes=6 behaves as 4.
  - start pulsed while busy → no effect on bus or latched fields.
- Reset asserted mid-RDATA:
  - SCL=1 and SDA=z within the reset cycle; busy=0, rx_data=0, no done pulse.
  - The next start after release runs a clean transaction.

Source files
------------

// File: rtl/i2c_master.sv
// i2c_master: single-command I2C bus master, quarter-phase SCL engine with open-drain SDA.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  slv_addr,
  input  logic [2:0]  num_bytes,
  input  logic [31:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [31:0] rx_data,
  output logic        SCL,
  inout  wire         SDA
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RACK, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] q, q_n, byte_idx, byte_n;
  logic [2:0] bits, bits_n, nb;
  logic [6:0] addr_r;
  logic [31:0] tx_r;
  logic rw_r, smp, sda_low, scl_n, sda_low_n, tick, slot_end, last, last_n;
  logic [7:0] addr_byte;
  assign tick = cnt == CW'(CLK_DIV - 1);
  assign slot_end = tick && q == 2'd3;
  assign addr_byte = {addr_r, rw_r};
  assign last = {1'b0, byte_idx} == nb - 3'd1;
  assign last_n = {1'b0, byte_n} == nb - 3'd1;
  assign SDA = sda_low ? 1'b0 : 1'bz;
  // one idle cycle after accept, then quarter counting; bits wraps to 0 after each byte
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    q_n = q;
    bits_n = bits;
    byte_n = byte_idx;
    if (busy && state == IDLE) begin
      state_n = START;
      cnt_n = '0;
      q_n = '0;
    end else if (busy) begin
      cnt_n = tick ? '0 : cnt + 1'b1;
      q_n = tick ? q + 2'd1 : q;
      if (slot_end)
        case (state)
          START: begin
            state_n = ADDR;
            bits_n = '0;
          end
          ADDR, WDATA, RDATA: begin
            bits_n = bits + 3'd1;
            if (bits == 3'd7) state_n = state == ADDR ? ADDR_ACK : state == WDATA ? WACK : RACK;
          end
          ADDR_ACK: begin
            state_n = (smp || nb == 3'd0) ? STOP : rw_r ? RDATA : WDATA;
            byte_n = '0;
          end
          WACK: begin
            state_n = (smp || last) ? STOP : WDATA;
            byte_n = byte_idx + 2'd1;
          end
          RACK: begin
            state_n = last ? STOP : RDATA;
            byte_n = byte_idx + 2'd1;
          end
          STOP: state_n = IDLE;
          default: ;
        endcase
    end
  end
  // bus levels are decoded from the upcoming state/quarter so SCL/SDA come straight from flops
  always_comb begin
    scl_n = 1'b1;
    sda_low_n = 1'b0;
    case (state_n)
      START: sda_low_n = q_n[1];
      ADDR: begin
        scl_n = q_n[1];
        sda_low_n = ~addr_byte[~bits_n];
      end
      WDATA: begin
        scl_n = q_n[1];
        sda_low_n = ~tx_r[{~byte_n, ~bits_n}];
      end
      ADDR_ACK, WACK, RDATA: scl_n = q_n[1];
      RACK: begin
        scl_n = q_n[1];
        sda_low_n = ~last_n;
      end
      STOP: begin
        scl_n = q_n != 2'd0;
        sda_low_n = ~q_n[1];
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      bits <= '0;
      byte_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      ack_err <= 1'b0;
      rx_data <= '0;
      SCL <= 1'b1;
      sda_low <= 1'b0;
      smp <= 1'b0;
      rw_r <= 1'b0;
      addr_r <= '0;
      nb <= '0;
      tx_r <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      q <= q_n;
      bits <= bits_n;
      byte_idx <= byte_n;
      SCL <= scl_n;
      sda_low <= sda_low_n;
      done <= busy && state == STOP && slot_end;
      if (start && !busy) begin
        busy <= 1'b1;
        rw_r <= rw;
        addr_r <= slv_addr;
        nb <= num_bytes > 3'd4 ? 3'd4 : num_bytes;
        tx_r <= tx_data;
        ack_err <= 1'b0;
        if (rw) rx_data <= '0;
      end else if (busy && state == STOP && slot_end) begin
        busy <= 1'b0;
      end
      if (busy && state != IDLE && tick && q == 2'd2) begin
        smp <= SDA;
        if (state == RDATA) rx_data[{~byte_idx, ~bits}] <= SDA;
      end
      if (slot_end && smp && (state == ADDR_ACK || state == WACK)) ack_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized scoreboard bench with an I2C slave model at 0x55 and a bus decoder.
module tb_i2c_master;
  localparam int D = 4;
  logic clk = 0, rst_n = 0, start = 0, rw = 0;
  logic [6:0] slv_addr = '0;
  logic [2:0] num_bytes = '0;
  logic [31:0] tx_data = '0;
  logic busy, done, ack_err, scl;
  logic [31:0] rx_data;
  wire sda;
  pullup (sda);
  logic sl_drive = 0;
  int sl_nack = 8;
  logic [31:0] sl_rd = '0;
  assign sda = (sl_drive && rst_n) ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(rst_n), .start(start), .rw(rw), .slv_addr(slv_addr),
    .num_bytes(num_bytes), .tx_data(tx_data), .busy(busy), .done(done),
    .ack_err(ack_err), .rx_data(rx_data), .SCL(scl), .SDA(sda)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    int lat;
    bit err;
    bit rd;
    logic [31:0] rx;
    int nb;
    logic [39:0] b;
    int nma;
  } exp_t;

  exp_t sb[$];
  int errs = 0, checks = 0, cyc = 0;
  bit prev_err = 0;
  logic [7:0] log_b[$];
  bit log_a[$];
  int n_start = 0, n_stop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transaction-level expectation: bytes on the bus, errors, readout and timing
  function automatic exp_t model(input bit r, input logic [6:0] a, input logic [2:0] nraw,
                                 input logic [31:0] tx, input int nk, input logic [31:0] rd);
    exp_t e;
    int n, slots;
    logic [31:0] src;
    logic [7:0] by;
    n = nraw > 3'd4 ? 4 : int'(nraw);
    src = r ? rd : tx;
    e.acc = 0;
    e.rd = r;
    e.err = 0;
    e.rx = '0;
    e.nma = 0;
    e.b = '0;
    e.b[39:32] = {a, r};
    e.nb = 1;
    slots = 11;
    if (a != 7'h55) e.err = 1;
    else
      for (int i = 0; i < n; i++) begin
        by = src[31 - 8 * i -: 8];
        e.b[31 - 8 * i -: 8] = by;
        e.nb++;
        slots += 9;
        if (r) begin
          e.rx[31 - 8 * i -: 8] = by;
          e.nma++;
        end else if (i == nk) begin
          e.err = 1;
          break;
        end
      end
    e.lat = 1 + 4 * D * slots;
    return e;
  endfunction

  // slave model and bus decoder, sampled once per system clock
  initial begin
    bit ps, pd, cs, cd, in_x, rd_mode, addressed, talk, lastack;
    int bc, bn;
    logic [7:0] sh, rb;
    ps = 1; pd = 1; in_x = 0; rd_mode = 0; addressed = 0; talk = 0; lastack = 1;
    bc = 0; bn = 0; sh = '0; rb = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        in_x = 0; sl_drive = 0; talk = 0; bc = 0; ps = 1; pd = 1;
      end else begin
        cs = scl;
        cd = sda;
        if (ps && cs && pd && !cd) begin
          n_start++;
          in_x = 1; bc = 0; bn = 0; sl_drive = 0; rd_mode = 0; addressed = 0; talk = 0;
        end else if (ps && cs && !pd && cd) begin
          n_stop++;
          in_x = 0; sl_drive = 0; talk = 0;
        end else if (in_x && !ps && cs) begin
          if (bc < 8) begin
            sh = {sh[6:0], cd};
            bc++;
            if (bc == 8) log_b.push_back(sh);
          end else begin
            bc = 9;
            lastack = cd;
            if (rd_mode && bn > 0) log_a.push_back(cd);
          end
        end else if (in_x && ps && !cs) begin
          if (bc == 8) begin
            talk = 0;
            if (bn == 0) begin
              addressed = sh[7:1] == 7'h55;
              rd_mode = sh[0];
              sl_drive = addressed;
            end else sl_drive = !rd_mode && (bn - 1 != sl_nack);
          end else if (bc == 9) begin
            bn++;
            bc = 0;
            talk = rd_mode && addressed && (bn == 1 || !lastack) && bn <= 4;
            if (talk) begin
              rb = sl_rd[39 - 8 * bn -: 8];
              sl_drive = !rb[7];
            end else sl_drive = 0;
          end else if (bc >= 1 && bc <= 7 && talk) sl_drive = !rb[7 - bc];
        end
        ps = cs;
        pd = cd;
      end
    end
  end

  // scoreboard monitor: every done pulse is matched against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) chk("unexpected done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done latency", cyc - e.acc, e.lat);
          chk("busy at done", busy, 0);
          chk("ack_err", ack_err, e.err);
          if (e.rd) chk("rx_data", rx_data, e.rx);
          chk("bus byte count", log_b.size(), e.nb);
          for (int i = 0; i < e.nb && i < log_b.size(); i++) chk("bus byte", log_b[i], e.b[39 - 8 * i -: 8]);
          chk("master ack count", log_a.size(), e.nma);
          for (int i = 0; i < e.nma && i < log_a.size(); i++) chk("master ack bit", log_a[i], i == e.nma - 1);
          chk("start count", n_start, 1);
          chk("stop count", n_stop, 1);
        end
      end
    end
  end

  task automatic issue(input bit r, input logic [6:0] a, input logic [2:0] n, input logic [31:0] tx,
                       input int nk, input logic [31:0] rd, input int glitch = 0, input int rst_at = 0);
    exp_t e;
    int t;
    sl_nack = nk;
    sl_rd = rd;
    e = model(r, a, n, tx, nk, rd);
    @(posedge clk);
    #1;
    log_b.delete();
    log_a.delete();
    n_start = 0;
    n_stop = 0;
    chk("ack_err sticky", ack_err, prev_err);
    rw = r; slv_addr = a; num_bytes = n; tx_data = tx; start = 1;
    @(posedge clk);
    #1;
    start = 0;
    e.acc = cyc;
    sb.push_back(e);
    chk("busy after accept", busy, 1);
    if (r) chk("rx cleared on accept", rx_data, 0);
    t = 0;
    while (!done && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
      if (t == glitch) begin
        start = 1; rw = ~r; slv_addr = 7'h22; num_bytes = 3'd1; tx_data = ~tx;
      end else start = 0;
      if (t == rst_at) begin
        #2 rst_n = 0;
        #1;
        chk("reset scl", scl, 1);
        chk("reset sda", sda, 1);
        chk("reset busy", busy, 0);
        chk("reset rx_data", rx_data, 0);
        chk("reset done", done, 0);
        sb.delete(sb.size() - 1);
        repeat (3) begin
          @(posedge clk);
          #1;
          chk("no done in reset", done, 0);
        end
        rst_n = 1;
        prev_err = 0;
        return;
      end
    end
    chk("done seen", done, 1);
    prev_err = e.err;
    @(posedge clk);
    #1;
    chk("done one cycle", done, 0);
  endtask

  initial begin
    bit r;
    logic [6:0] a;
    logic [2:0] n;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset scl", scl, 1);
    chk("reset sda", sda, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ack_err", ack_err, 0);
    chk("reset rx_data", rx_data, 0);
    rst_n = 1;
    issue(0, 7'h55, 3'd4, 32'h11123441, 8, 0);
    issue(1, 7'h55, 3'd4, 0, 8, 32'hDEADBEEF);
    issue(0, 7'h22, 3'd2, 32'hA5A5A5A5, 8, 0);
    issue(0, 7'h55, 3'd3, 32'hCAFEF00D, 1, 0);
    issue(0, 7'h55, 3'd0, 0, 8, 0);
    issue(0, 7'h55, 3'd6, 32'h01020304, 8, 0);
    issue(1, 7'h55, 3'd6, 0, 8, 32'h89ABCDEF);
    issue(1, 7'h55, 3'd2, 0, 8, 32'h12345678);
    issue(0, 7'h55, 3'd4, 32'h5A5AC3C3, 8, 0, 50);
    issue(1, 7'h55, 3'd4, 0, 8, 32'h0F0F0F0F, 0, 217);
    issue(1, 7'h55, 3'd4, 0, 8, 32'hFEEDC0DE);
    for (int k = 0; k < 15; k++) begin
      r = 1'($urandom_range(0, 1));
      a = $urandom_range(0, 3) == 0 ? 7'($urandom) : 7'h55;
      n = r ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
      issue(r, a, n, $urandom, int'($urandom_range(0, 8)), $urandom);
    end
    repeat (5) @(posedge clk);
    chk("scoreboard drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
